// File: rtl/cacheline_adaptor.sv
// Bridges a 256-bit cache line port to a 64-bit burst memory: fills gather beats, writebacks split them.
// Request to IDLE is at least 6 cycles; the memory paces each beat with resp_i, and resp_o pulses once per line.
module cacheline_adaptor #(
  parameter int line_width  = 256,
  parameter int burst_width = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [line_width-1:0]  line_i,
  output logic [line_width-1:0]  line_o,
  input  logic [31:0]            address_i,
  input  logic                   read_i,
  input  logic                   write_i,
  output logic                   resp_o,
  input  logic [burst_width-1:0] burst_i,
  output logic [burst_width-1:0] burst_o,
  output logic [31:0]            address_o,
  output logic                   read_o,
  output logic                   write_o,
  input  logic                   resp_i
);

  localparam int beats = line_width / burst_width;
  localparam int cw    = (beats > 1) ? $clog2(beats) : 1;
  localparam logic [cw-1:0] last_cnt = cw'(beats - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]            state;
  logic [cw-1:0]         cnt;
  logic [line_width-1:0] line_q;
  logic [31:0]           addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      line_q <= '0;
      addr_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Writeback wins over fill when the cache raises both.
          if (write_i) begin
            line_q <= line_i;
            addr_q <= {address_i[31:5], 5'b0};
            cnt    <= '0;
            state  <= WRITE;
          end else if (read_i) begin
            addr_q <= {address_i[31:5], 5'b0};
            cnt    <= '0;
            state  <= READ;
          end
        end
        READ: begin
          if (resp_i) begin
            line_q[int'(cnt)*burst_width +: burst_width] <= burst_i;
            if (cnt == last_cnt) begin
              cnt   <= '0;
              state <= DONE;
            end else begin
              cnt <= cnt + cw'(1);
            end
          end
        end
        WRITE: begin
          if (resp_i) begin
            if (cnt == last_cnt) begin
              cnt   <= '0;
              state <= DONE;
            end else begin
              cnt <= cnt + cw'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign read_o    = (state == READ);
  assign write_o   = (state == WRITE);
  assign resp_o    = (state == DONE);
  assign address_o = addr_q;
  assign line_o    = line_q;
  // Only combinational path: the outgoing beat follows the counter.
  assign burst_o   = line_q[int'(cnt)*burst_width +: burst_width];

endmodule
